dbg_run_ctrl: RTL and testbench

DBG_RUN_CTRL -- requirements
Module: dbg_run_ctrl

---
 rtl/dbg_pkg.sv | 17 +
 rtl/dbg_clk_gate.sv | 19 +
 rtl/dbg_run_ctrl.sv | 118 +++++++++++
 tb/tb_dbg_run_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared types for the debug run controller: FSM state and halt cause encodings.
package dbg_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } dbg_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_JTAG = 2'd1,
        CAUSE_BKPT = 2'd2,
        CAUSE_STEP = 2'd3
    } halt_cause_t;

endpackage

// File: rtl/dbg_clk_gate.sv
// Glitch-free core clock gate: enable captured on the falling edge, ANDed with sys_clk.
module dbg_clk_gate (
    input  logic sys_clk,
    input  logic dbg_rst,
    input  logic en,
    output logic gclk
);

    logic gate_q;

    // Resets open so the core clock runs straight out of reset.
    always_ff @(negedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) gate_q <= 1'b1;
        else          gate_q <= en;
    end

    assign gclk = sys_clk & gate_q;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run/halt/step controller driving a gated core clock and a run-cycle counter.
module dbg_run_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned STEP_W = 8,
    parameter int unsigned CYC_W  = 32
) (
    input  logic              sys_clk,
    input  logic              dbg_rst,
    input  logic              halt_stb,
    input  logic              step_stb,
    input  logic              resume_stb,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bkpt_en,
    input  logic              bkpt_hit,
    output logic              dbg_clk,
    output logic              halted,
    output logic              step_done,
    output logic [1:0]        halt_cause,
    output logic [CYC_W-1:0]  run_cycles
);

    dbg_state_t        state_q, state_d;
    halt_cause_t       cause_q, cause_d;
    logic              clk_en_q, clk_en_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [CYC_W-1:0]  run_cnt_q, run_cnt_d;

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        clk_en_d = clk_en_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        // clk_en only moves on posedge, so it equals the negedge gate at every rising edge.
        run_cnt_d = clk_en_q ? run_cnt_q + CYC_W'(1) : run_cnt_q;

        case (state_q)
            RUN: begin
                if (halt_stb) begin
                    state_d  = HALT;
                    clk_en_d = 1'b0;
                    cause_d  = CAUSE_JTAG;
                end else if (bkpt_en && bkpt_hit) begin
                    state_d  = HALT;
                    clk_en_d = 1'b0;
                    cause_d  = CAUSE_BKPT;
                end
            end
            HALT: begin
                if (halt_stb) begin
                    state_d = HALT;
                end else if (step_stb) begin
                    state_d  = STEP;
                    clk_en_d = 1'b1;
                    cnt_d    = (step_count == '0) ? STEP_W'(1) : step_count;
                end else if (resume_stb) begin
                    state_d  = RUN;
                    clk_en_d = 1'b1;
                    cause_d  = CAUSE_NONE;
                end
            end
            STEP: begin
                if (halt_stb) begin
                    state_d  = HALT;
                    clk_en_d = 1'b0;
                    cause_d  = CAUSE_JTAG;
                    cnt_d    = '0;
                end else if (cnt_q == STEP_W'(1)) begin
                    state_d  = HALT;
                    clk_en_d = 1'b0;
                    cause_d  = CAUSE_STEP;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                end
            end
            default: begin
                state_d  = RUN;
                clk_en_d = 1'b1;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) begin
            state_q   <= RUN;
            cause_q   <= CAUSE_NONE;
            clk_en_q  <= 1'b1;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            clk_en_q  <= clk_en_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    dbg_clk_gate u_clk_gate (
        .sys_clk (sys_clk),
        .dbg_rst (dbg_rst),
        .en      (clk_en_q),
        .gclk    (dbg_clk)
    );

    assign halted     = (state_q == HALT);
    assign step_done  = done_q;
    assign halt_cause = cause_q;
    assign run_cycles = run_cnt_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed self-checking bench for dbg_run_ctrl: run, halt, step, breakpoints, wrap, reset.
module tb_dbg_run_ctrl;

    logic        sys_clk = 1'b0;
    logic        dbg_rst = 1'b0;
    logic        halt_stb = 1'b0, step_stb = 1'b0, resume_stb = 1'b0;
    logic [7:0]  step_count = 8'd0;
    logic        bkpt_en = 1'b0, bkpt_hit = 1'b0;
    logic        dbg_clk, halted, step_done;
    logic [1:0]  halt_cause;
    logic [31:0] run_cycles;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned edge_cnt = 0;
    int unsigned e0 = 0;
    logic        done_seen = 1'b0;
    time         rise_t = 0;

    dbg_run_ctrl #(.STEP_W(8), .CYC_W(32)) dut (
        .sys_clk    (sys_clk),
        .dbg_rst    (dbg_rst),
        .halt_stb   (halt_stb),
        .step_stb   (step_stb),
        .resume_stb (resume_stb),
        .step_count (step_count),
        .bkpt_en    (bkpt_en),
        .bkpt_hit   (bkpt_hit),
        .dbg_clk    (dbg_clk),
        .halted     (halted),
        .step_done  (step_done),
        .halt_cause (halt_cause),
        .run_cycles (run_cycles)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge dbg_clk) begin
        rise_t   = $time;
        edge_cnt = edge_cnt + 1;
    end

    // Every high phase of the gated clock must last a full half period.
    always @(negedge dbg_clk) begin
        checks = checks + 1;
        assert (($time - rise_t) >= 5)
        else begin
            errors = errors + 1;
            $error("FAIL glitch observed_high=%0t required_min=5", $time - rise_t);
        end
    end

    always @(negedge sys_clk) if (step_done) done_seen = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_halted", halted, 0);
        chk("rst_done", step_done, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cycles", run_cycles, 0);
        dbg_rst = 1'b1;
        e0 = edge_cnt;

        // Free run for 10 cycles
        repeat (10) tick();
        chk("run_cycles10", run_cycles, 10);
        chk("run_halted", halted, 0);
        chk("run_edges", edge_cnt - e0, 10);

        // JTAG halt from RUN, clock stops
        halt_stb = 1'b1; tick(); halt_stb = 1'b0;
        chk("halt_halted", halted, 1);
        chk("halt_cause", halt_cause, 1);
        chk("halt_cycles", run_cycles, 11);
        repeat (5) tick();
        chk("halt_edges", edge_cnt - e0, 11);
        chk("halt_cycles_hold", run_cycles, 11);

        // Step of 3; step_count changes after entry must be ignored
        e0 = edge_cnt; done_seen = 1'b0;
        step_count = 8'd3; step_stb = 1'b1; tick(); step_stb = 1'b0; step_count = 8'd50;
        chk("s3_entry_halted", halted, 0);
        chk("s3_entry_edges", edge_cnt - e0, 0);
        tick(); chk("s3_done_c1", step_done, 0);
        tick(); chk("s3_done_c2", step_done, 0);
        tick();
        chk("s3_done", step_done, 1);
        chk("s3_halted", halted, 1);
        chk("s3_cause", halt_cause, 3);
        chk("s3_edges", edge_cnt - e0, 3);
        tick();
        chk("s3_done_pulse", step_done, 0);
        chk("s3_edges_after", edge_cnt - e0, 3);
        chk("s3_cycles", run_cycles, 14);

        // Step of 0 behaves as 1
        e0 = edge_cnt;
        step_count = 8'd0; step_stb = 1'b1; tick(); step_stb = 1'b0;
        tick();
        chk("s0_done", step_done, 1);
        chk("s0_edges", edge_cnt - e0, 1);
        tick();
        chk("s0_done_pulse", step_done, 0);
        chk("s0_edges_after", edge_cnt - e0, 1);
        chk("s0_halted", halted, 1);

        // Step of 200 aborted by halt_stb 10 cycles in; resume during STEP dropped
        e0 = edge_cnt; done_seen = 1'b0;
        step_count = 8'd200; step_stb = 1'b1; tick(); step_stb = 1'b0;
        tick(); tick();
        resume_stb = 1'b1; tick(); resume_stb = 1'b0;
        chk("abort_resume_dropped", halted, 0);
        repeat (6) tick();
        halt_stb = 1'b1; tick(); halt_stb = 1'b0;
        chk("abort_halted", halted, 1);
        chk("abort_cause", halt_cause, 1);
        tick();
        chk("abort_edges", edge_cnt - e0, 10);
        chk("abort_no_done", done_seen, 0);
        chk("abort_cycles", run_cycles, 25);

        // HALT priority: halt_stb beats step_stb; step_stb beats resume_stb
        e0 = edge_cnt;
        halt_stb = 1'b1; step_stb = 1'b1; tick(); halt_stb = 1'b0; step_stb = 1'b0;
        chk("prio_halt_noop", halted, 1);
        chk("prio_halt_edges", edge_cnt - e0, 0);
        step_count = 8'd2; step_stb = 1'b1; resume_stb = 1'b1; tick();
        step_stb = 1'b0; resume_stb = 1'b0;
        chk("prio_step_taken", halted, 0);
        tick(); tick();
        chk("prio_step_done", step_done, 1);
        chk("prio_step_cause", halt_cause, 3);
        chk("prio_step_edges", edge_cnt - e0, 2);

        // Resume, then step_stb ignored in RUN, breakpoint gating
        resume_stb = 1'b1; tick(); resume_stb = 1'b0;
        chk("resume_halted", halted, 0);
        chk("resume_cause", halt_cause, 0);
        step_stb = 1'b1; tick(); step_stb = 1'b0;
        chk("run_step_ignored", halted, 0);
        bkpt_hit = 1'b1; tick();
        chk("bkpt_disabled", halted, 0);
        bkpt_en = 1'b1; tick(); bkpt_en = 1'b0; bkpt_hit = 1'b0;
        chk("bkpt_halted", halted, 1);
        chk("bkpt_cause", halt_cause, 2);
        resume_stb = 1'b1; tick(); resume_stb = 1'b0;
        bkpt_en = 1'b1; bkpt_hit = 1'b1; halt_stb = 1'b1; tick(); halt_stb = 1'b0;
        chk("bkpt_jtag_halted", halted, 1);
        chk("bkpt_jtag_cause", halt_cause, 1);

        // Breakpoint held through a step is ignored
        step_count = 8'd2; step_stb = 1'b1; tick(); step_stb = 1'b0;
        tick();
        chk("step_bkpt_ignored", halted, 0);
        tick();
        chk("step_bkpt_done", step_done, 1);
        chk("step_bkpt_cause", halt_cause, 3);
        bkpt_en = 1'b0; bkpt_hit = 1'b0;

        // run_cycles wrap
        resume_stb = 1'b1; tick(); resume_stb = 1'b0;
        @(negedge sys_clk);
        force dut.run_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.run_cnt_q;
        tick(); chk("wrap_max", run_cycles, 32'hFFFF_FFFF);
        tick(); chk("wrap_zero", run_cycles, 0);
        tick(); chk("wrap_one", run_cycles, 1);

        // Reset in the middle of a step
        halt_stb = 1'b1; tick(); halt_stb = 1'b0;
        step_count = 8'd5; step_stb = 1'b1; tick(); step_stb = 1'b0;
        tick(); tick();
        done_seen = 1'b0;
        dbg_rst = 1'b0; #1;
        chk("mrst_halted", halted, 0);
        chk("mrst_done", step_done, 0);
        chk("mrst_cause", halt_cause, 0);
        chk("mrst_cycles", run_cycles, 0);
        tick();
        dbg_rst = 1'b1;
        repeat (8) tick();
        chk("mrst_no_done", done_seen, 0);
        chk("mrst_run", halted, 0);
        chk("mrst_cycles_after", run_cycles, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
